// File: rtl/riscv_multicycle.sv
// Three-state (FETCH/EXEC/WB) RV32I-subset core: one instruction per 3 cycles.
// instr accepted only in FETCH; results registered at end of EXEC, committed at end of WB.
module riscv_multicycle #(
  parameter int              XLEN     = 32,
  parameter int              NUM_REGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] aluresult,
  output logic            branch_taken,
  output logic            retire,
  output logic            illegal
);

  localparam int RW = $clog2(NUM_REGS);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {FETCH, EXEC, WB} state_t;

  state_t            state_q, state_d;
  logic [31:0]       instr_q;
  logic [XLEN-1:0]   regs [NUM_REGS];
  logic [XLEN-1:0]   npc_q;
  logic              ill_q;
  logic              wr_q;
  logic [4:0]        rd_q;

  // Field extraction from the latched instruction
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_b, rs1_val, rs2_val, op_b;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];
  assign imm_i  = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign imm_b  = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                   instr_q[30:25], instr_q[11:8], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1[RW-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2[RW-1:0]];
  assign op_b    = (opcode == OPC_OP_IMM) ? imm_i : rs2_val;

  // FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (instr_valid) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  assign instr_ready = (state_q == FETCH);
  assign retire      = (state_q == WB);
  assign illegal     = (state_q == WB) && ill_q;

  // Execute: decode, compute, legality
  logic [XLEN-1:0] alu_d, npc_d, diff;
  logic            bt_d, ill_d, wr_d, use_rs1, use_rs2, use_rd, reg_bad;

  assign diff = rs1_val - rs2_val;

  always_comb begin
    alu_d   = '0;
    bt_d    = 1'b0;
    ill_d   = 1'b0;
    wr_d    = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    npc_d   = pc + XLEN'(4);
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        use_rs1 = 1'b1;
        use_rs2 = (opcode == OPC_OP);
        use_rd  = 1'b1;
        wr_d    = 1'b1;
        if (opcode == OPC_OP && funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) alu_d = rs1_val - rs2_val;
          else                  ill_d = 1'b1;
        end else if (opcode == OPC_OP && funct7 != 7'b0000000) begin
          ill_d = 1'b1;
        end else begin
          case (funct3)
            3'b000:  alu_d = rs1_val + op_b;
            3'b111:  alu_d = rs1_val & op_b;
            3'b110:  alu_d = rs1_val | op_b;
            3'b100:  alu_d = rs1_val ^ op_b;
            3'b010:  alu_d = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(op_b))};
            default: ill_d = 1'b1;
          endcase
        end
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        alu_d   = diff;
        case (funct3)
          3'b000:  bt_d = (diff == '0);
          3'b001:  bt_d = (diff != '0);
          default: ill_d = 1'b1;
        endcase
        if (bt_d) npc_d = pc + imm_b;
      end
      default: ill_d = 1'b1;
    endcase

    // RV32E: register fields beyond the implemented file are illegal
    reg_bad = (use_rs1 && (32'(rs1) >= NUM_REGS)) ||
              (use_rs2 && (32'(rs2) >= NUM_REGS)) ||
              (use_rd  && (32'(rd)  >= NUM_REGS));
    if (reg_bad) ill_d = 1'b1;

    if (ill_d) begin
      alu_d = '0;
      bt_d  = 1'b0;
      wr_d  = 1'b0;
      npc_d = pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      instr_q      <= '0;
      pc           <= RESET_PC;
      npc_q        <= RESET_PC;
      aluresult    <= '0;
      branch_taken <= 1'b0;
      ill_q        <= 1'b0;
      wr_q         <= 1'b0;
      rd_q         <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && instr_valid) instr_q <= instr;
      if (state_q == EXEC) begin
        aluresult    <= alu_d;
        branch_taken <= bt_d;
        ill_q        <= ill_d;
        wr_q         <= wr_d;
        rd_q         <= rd;
        npc_q        <= npc_d;
      end
      if (state_q == WB) begin
        pc <= npc_q;
        if (wr_q && rd_q != 5'd0) regs[rd_q[RW-1:0]] <= aluresult;
      end
    end
  end

endmodule

// File: tb/tb_riscv_multicycle.sv
// Scoreboard bench for riscv_multicycle (RV32E build): directed program, monitor checks each retire.
module tb_riscv_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready, branch_taken, retire, illegal;
  logic [31:0] pc, aluresult;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] alu;
    logic        bt;
    logic        ill;
    logic [31:0] npc;
  } exp_t;

  exp_t exp_q[$];

  riscv_multicycle #(.XLEN(32), .NUM_REGS(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .pc(pc), .aluresult(aluresult),
    .branch_taken(branch_taken), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Monitor: every retire pops one expectation; pc is checked on the following cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (retire) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: retire=1 with nothing expected, pc=%h", pc);
        end else begin
          e = exp_q.pop_front();
          check("aluresult", aluresult, e.alu);
          check("branch_taken", 32'(branch_taken), 32'(e.bt));
          check("illegal", 32'(illegal), 32'(e.ill));
          @(negedge clk);
          check("pc_after_wb", pc, e.npc);
        end
      end
    end
  end

  // Present one instruction, hold until accepted, then let it run through EXEC and WB.
  task automatic issue(input logic [31:0] ins, input logic [31:0] alu, input logic bt,
                       input logic ill, input logic [31:0] npc, input logic expect_retire);
    int n = 0;
    exp_t e;
    e.alu = alu; e.bt = bt; e.ill = ill; e.npc = npc;
    if (expect_retire) exp_q.push_back(e);
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: instr_ready=%b expected 1", instr_ready);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 32'hFFFF_FFFF;
    if (expect_retire) repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_pc", pc, 32'h0);
    check("rst_aluresult", aluresult, 32'h0);
    check("rst_branch_taken", 32'(branch_taken), 32'h0);
    check("rst_retire", 32'(retire), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    check("rst_instr_ready", 32'(instr_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(enc_i(12'd5, 5'd0, 3'b000, 5'd1),            32'd5,          1'b0, 1'b0, 32'd4,  1'b1); // ADDI x1,x0,5
    issue(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2),      32'd10,         1'b0, 1'b0, 32'd8,  1'b1); // ADD x2,x1,x1
    issue(enc_r(7'h20, 5'd1, 5'd0, 3'b000, 5'd3),      32'hFFFF_FFFB,  1'b0, 1'b0, 32'd12, 1'b1); // SUB x3,x0,x1
    issue(enc_r(7'h00, 5'd1, 5'd3, 3'b010, 5'd4),      32'd1,          1'b0, 1'b0, 32'd16, 1'b1); // SLT x4,x3,x1
    issue(enc_b(13'd8, 5'd1, 5'd1, 3'b000),            32'd0,          1'b1, 1'b0, 32'd24, 1'b1); // BEQ taken
    issue(enc_b(13'd8, 5'd1, 5'd1, 3'b001),            32'd0,          1'b0, 1'b0, 32'd28, 1'b1); // BNE not taken
    issue(enc_i(12'd7, 5'd0, 3'b000, 5'd0),            32'd7,          1'b0, 1'b0, 32'd32, 1'b1); // ADDI x0,x0,7
    issue(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd6),      32'd0,          1'b0, 1'b0, 32'd36, 1'b1); // ADD x6,x0,x0
    issue(32'h0000_00FF,                               32'd0,          1'b0, 1'b1, 32'd40, 1'b1); // opcode 7F
    issue(enc_i(12'd0, 5'd1, 3'b000, 5'd7),            32'd5,          1'b0, 1'b0, 32'd44, 1'b1); // ADDI x7,x1,0
    issue(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd17),     32'd0,          1'b0, 1'b1, 32'd48, 1'b1); // ADD x17 (RV32E)

    // Idle: no valid for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_instr_ready", 32'(instr_ready), 32'h1);
      check("idle_pc", pc, 32'd48);
    end

    issue(enc_i(12'h0F0, 5'd3, 3'b111, 5'd8),          32'h0000_00F0,  1'b0, 1'b0, 32'd52, 1'b1); // ANDI
    issue(enc_i(12'hFF0, 5'd1, 3'b110, 5'd9),          32'hFFFF_FFF5,  1'b0, 1'b0, 32'd56, 1'b1); // ORI
    issue(enc_i(12'hFFF, 5'd1, 3'b100, 5'd10),         32'hFFFF_FFFA,  1'b0, 1'b0, 32'd60, 1'b1); // XORI
    issue(enc_i(12'hFFC, 5'd3, 3'b010, 5'd11),         32'd1,          1'b0, 1'b0, 32'd64, 1'b1); // SLTI -5<-4
    issue(enc_r(7'h00, 5'd3, 5'd1, 3'b100, 5'd12),     32'hFFFF_FFFE,  1'b0, 1'b0, 32'd68, 1'b1); // XOR
    issue(enc_b(13'h1FF8, 5'd0, 5'd1, 3'b001),         32'd5,          1'b1, 1'b0, 32'd60, 1'b1); // BNE back -8
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd13),     32'd15,         1'b0, 1'b0, 32'd64, 1'b1); // OR

    // Reset during EXEC of ADDI x5,x0,9: aborted, no retire
    issue(enc_i(12'd9, 5'd0, 3'b000, 5'd5), 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_pc", pc, 32'h0);
    check("abort_aluresult", aluresult, 32'h0);
    check("abort_branch_taken", 32'(branch_taken), 32'h0);
    check("abort_retire", 32'(retire), 32'h0);
    check("abort_instr_ready", 32'(instr_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(enc_i(12'd0, 5'd5, 3'b000, 5'd14),           32'd0,          1'b0, 1'b0, 32'd4,  1'b1); // x5 cleared
    issue(enc_i(12'd0, 5'd1, 3'b000, 5'd14),           32'd0,          1'b0, 1'b0, 32'd8,  1'b1); // x1 cleared

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
